// File: rtl/cnn_pkg.sv
// Shared types and constants for the cnn_engine classifier.
package cnn_pkg;
   typedef enum logic [2:0] {IDLE, CONV, DRAIN, FC, DONE} state_t;
   typedef logic [7:0]  pix_t;
   typedef logic [31:0] word_t;
   localparam int unsigned SAT_SHIFT = 8;
endpackage

// File: rtl/cnn_conv_lane.sv
// One convolution lane: 4-tap dot product, shift/saturate, POOL_SZ running max
// into 4 pooled bytes.
module cnn_conv_lane
   import cnn_pkg::*;
#(
   parameter int unsigned POOL_SZ = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            shift_en,
   input  logic [3:0][7:0] pixels,
   input  logic [3:0][7:0] kernel,
   output logic [3:0][7:0] pooled
);
   localparam int unsigned PW = (POOL_SZ > 1) ? $clog2(POOL_SZ) : 1;

   logic [17:0]   sum;
   logic [17:0]   shifted;
   pix_t          conv_sat;
   pix_t          conv_val;
   logic          conv_vld;
   logic [PW-1:0] sub_cnt;
   logic [1:0]    grp;

   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < 4; i++)
         sum = sum + 18'(pixels[i]) * 18'(kernel[i]);
      shifted  = sum >> SAT_SHIFT;
      conv_sat = (shifted > 18'd255) ? 8'hFF : shifted[7:0];
   end

   // Conv result is registered first; pooling consumes it one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_val <= '0;
         conv_vld <= 1'b0;
         sub_cnt  <= '0;
         grp      <= '0;
         pooled   <= '0;
      end else if (clear) begin
         conv_vld <= 1'b0;
         sub_cnt  <= '0;
         grp      <= '0;
         pooled   <= '0;
      end else begin
         conv_vld <= shift_en;
         if (shift_en)
            conv_val <= conv_sat;
         if (conv_vld) begin
            if (conv_val > pooled[grp])
               pooled[grp] <= conv_val;
            if (sub_cnt == PW'(POOL_SZ - 1)) begin
               sub_cnt <= '0;
               grp     <= grp + 2'd1;
            end else begin
               sub_cnt <= sub_cnt + PW'(1);
            end
         end
      end
   end
endmodule

// File: rtl/cnn_engine.sv
// Parametrised CNN classifier: register-file weights, parallel conv/pool lanes,
// sequential FC MAC with argmax. Optional score port via CNN_SCORE_OUT_EN.
module cnn_engine
   import cnn_pkg::*;
#(
   parameter  int unsigned NUM_KERNELS = 2,
   parameter  int unsigned NUM_SHAPES  = 4,
   parameter  int unsigned POOL_SZ     = 4,
   parameter  int unsigned ADDR_W      = 5,
   localparam int unsigned SCORE_W     = 16 + $clog2(NUM_KERNELS * 4)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              learn,
   input  logic              classify,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  word_t             load_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [3:0][7:0]   pixels,
   output logic              busy,
   output logic              result_valid,
   output logic [7:0]        result
`ifdef CNN_SCORE_OUT_EN
   ,
   output logic [SCORE_W-1:0] score
`endif
);
   localparam int unsigned NK   = NUM_KERNELS;
   localparam int unsigned NS   = NUM_SHAPES;
   localparam int unsigned NWIN = 4 * POOL_SZ;
   localparam int unsigned KW   = (NK > 1) ? $clog2(NK) : 1;
   localparam int unsigned SW   = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned WW   = $clog2(NWIN);

   state_t               state;
   logic [3:0][7:0]      kern   [NK];
   logic [3:0][7:0]      wmem   [NS][NK];
   logic [3:0][7:0]      pooled [NK];
   logic [WW-1:0]        win_cnt;
   logic                 drain_cnt;
   logic [SW-1:0]        s_cnt;
   logic [KW-1:0]        k_cnt;
   logic [1:0]           j_cnt;
   logic [SCORE_W-1:0]   acc;
   logic [SCORE_W-1:0]   best;
   logic [SW-1:0]        best_idx;

   logic                 load_en, hs, start;
   logic                 last_j, last_k, last_s;
   logic [15:0]          prod;
   logic [SCORE_W-1:0]   shape_total;
   logic                 upd;
   logic [SCORE_W-1:0]   nxt_best;
   logic [SW-1:0]        nxt_idx;

   always_comb begin
      load_en     = learn & load_valid & (state == IDLE);
      hs          = (state == CONV) & pix_valid;
      start       = (state == IDLE) & classify;
      last_j      = (j_cnt == 2'd3);
      last_k      = (k_cnt == KW'(NK - 1));
      last_s      = (s_cnt == SW'(NS - 1));
      prod        = 16'(pooled[k_cnt][j_cnt]) * 16'(wmem[s_cnt][k_cnt][j_cnt]);
      shape_total = acc + SCORE_W'(prod);
      // Strict compare keeps the lowest shape index on ties.
      upd         = last_j & last_k & (shape_total > best);
      nxt_best    = upd ? shape_total : best;
      nxt_idx     = upd ? s_cnt : best_idx;
   end

   for (genvar g = 0; g < NK; g++) begin : g_lane
      cnn_conv_lane #(.POOL_SZ(POOL_SZ)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clear    (start),
         .shift_en (hs),
         .pixels   (pixels),
         .kernel   (kern[g]),
         .pooled   (pooled[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pix_ready    <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
`ifdef CNN_SCORE_OUT_EN
         score        <= '0;
`endif
         win_cnt      <= '0;
         drain_cnt    <= 1'b0;
         s_cnt        <= '0;
         k_cnt        <= '0;
         j_cnt        <= '0;
         acc          <= '0;
         best         <= '0;
         best_idx     <= '0;
         for (int unsigned k = 0; k < NK; k++) begin
            kern[k] <= '0;
            for (int unsigned s = 0; s < NS; s++)
               wmem[s][k] <= '0;
         end
      end else begin
         result_valid <= 1'b0;
         if (load_en) begin
            for (int unsigned k = 0; k < NK; k++) begin
               if (load_addr == ADDR_W'(k))
                  kern[k] <= load_data;
               for (int unsigned s = 0; s < NS; s++)
                  if (load_addr == ADDR_W'(NK + s * NK + k))
                     wmem[s][k] <= load_data;
            end
         end
         case (state)
            IDLE: if (classify) begin
               state     <= CONV;
               pix_ready <= 1'b1;
               busy      <= 1'b1;
               win_cnt   <= '0;
            end
            CONV: if (pix_valid) begin
               if (win_cnt == WW'(NWIN - 1)) begin
                  state     <= DRAIN;
                  pix_ready <= 1'b0;
                  drain_cnt <= 1'b0;
               end else begin
                  win_cnt <= win_cnt + WW'(1);
               end
            end
            DRAIN: if (drain_cnt) begin
               state    <= FC;
               s_cnt    <= '0;
               k_cnt    <= '0;
               j_cnt    <= '0;
               acc      <= '0;
               best     <= '0;
               best_idx <= '0;
            end else begin
               drain_cnt <= 1'b1;
            end
            FC: if (last_j) begin
               j_cnt <= '0;
               if (last_k) begin
                  // Final shape: outputs take the combinational argmax directly.
                  acc      <= '0;
                  best     <= nxt_best;
                  best_idx <= nxt_idx;
                  k_cnt    <= '0;
                  if (last_s) begin
                     state        <= DONE;
                     result_valid <= 1'b1;
                     result       <= 8'(nxt_idx);
`ifdef CNN_SCORE_OUT_EN
                     score        <= nxt_best;
`endif
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end else begin
                  acc   <= shape_total;
                  k_cnt <= k_cnt + KW'(1);
               end
            end else begin
               acc   <= shape_total;
               j_cnt <= j_cnt + 2'd1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_engine.sv
// Self-checking bench for cnn_engine at default parameters; checks score when
// CNN_SCORE_OUT_EN is defined.
module tb_cnn_engine;
   localparam int unsigned NK = 2, NS = 4, POOL = 4;

   typedef struct {
      int unsigned res;
      longint unsigned sc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst, learn, classify, load_valid, pix_valid;
   logic [4:0]      load_addr;
   logic [31:0]     load_data;
   logic            pix_ready, busy, result_valid;
   logic [3:0][7:0] pixels;
   logic [7:0]      result;
`ifdef CNN_SCORE_OUT_EN
   logic [18:0]     score;
`endif

   cnn_engine #(.NUM_KERNELS(NK), .NUM_SHAPES(NS), .POOL_SZ(POOL), .ADDR_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .learn        (learn),
      .classify     (classify),
      .load_valid   (load_valid),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pixels       (pixels),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result)
`ifdef CNN_SCORE_OUT_EN
      ,
      .score        (score)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0, n_fail = 0, n_strobe = 0;
   int unsigned cyc = 0, last_hs = 0;
   exp_t        exp_q[$];
   logic [31:0] m_kern [NK];
   logic [31:0] m_w    [NS][NK];
   logic [31:0] cur_win[16];

   task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: direct arithmetic on the address-mapped weights.
   function automatic exp_t model();
      exp_t e;
      int unsigned pl[NK][4];
      logic [31:0] x, kv, wv;
      longint unsigned sc, best;
      for (int k = 0; k < NK; k++)
         for (int g = 0; g < 4; g++) begin
            pl[k][g] = 0;
            for (int p = 0; p < POOL; p++) begin
               int unsigned dot, c;
               x = cur_win[g * POOL + p];
               kv = m_kern[k];
               dot = 0;
               for (int i = 0; i < 4; i++) dot += x[8*i +: 8] * kv[8*i +: 8];
               c = dot / 256;
               if (c > 255) c = 255;
               if (c > pl[k][g]) pl[k][g] = c;
            end
         end
      best = 0;
      e.res = 0;
      for (int s = 0; s < NS; s++) begin
         sc = 0;
         for (int k = 0; k < NK; k++) begin
            wv = m_w[s][k];
            for (int j = 0; j < 4; j++) sc += pl[k][j] * wv[8*j +: 8];
         end
         if (s == 0 || sc > best) begin
            best = sc;
            e.res = s;
         end
      end
      e.sc = best;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst) begin
         if (pix_valid && pix_ready) last_hs = cyc;
         if (result_valid) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
               chk("spurious_result_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("result", result, e.res);
               chk("latency", cyc - last_hs, 35);
`ifdef CNN_SCORE_OUT_EN
               chk("score", score, e.sc);
`endif
            end
         end
      end
   end

   task automatic model_write(input int unsigned addr, input logic [31:0] data);
      if (addr < NK) m_kern[addr] = data;
      else if (addr < NK * (1 + NS)) m_w[(addr - NK) / NK][(addr - NK) % NK] = data;
   endtask

   task automatic load(input int unsigned addr, input logic [31:0] data);
      learn = 1'b1; load_valid = 1'b1; load_addr = 5'(addr); load_data = data;
      @(posedge clk); #1;
      learn = 1'b0; load_valid = 1'b0;
      model_write(addr, data);
   endtask

   task automatic load_all(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] wall);
      load(0, k0);
      load(1, k1);
      for (int unsigned a = 2; a < 10; a++) load(a, wall);
   endtask

   task automatic start_class(input bit with_load, input int unsigned addr, input logic [31:0] data,
                              output exp_t e);
      classify = 1'b1;
      if (with_load) begin
         learn = 1'b1; load_valid = 1'b1; load_addr = 5'(addr); load_data = data;
         model_write(addr, data);
      end
      e = model();
      exp_q.push_back(e);
      @(posedge clk); #1;
      classify = 1'b0; learn = 1'b0; load_valid = 1'b0;
   endtask

   task automatic feed(input int gap_at, input bit noise);
      for (int i = 0; i < 16; i++) begin
         bit got;
         int unsigned t;
         if (i == gap_at) begin
            pix_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
         end
         pixels = cur_win[i];
         pix_valid = 1'b1;
         if (noise && i == 5) begin
            classify = 1'b1; learn = 1'b1; load_valid = 1'b1;
            load_addr = 5'd2; load_data = 32'hFFFF_FFFF;
         end
         got = 1'b0; t = 0;
         while (!got && t < 50) begin
            @(negedge clk);
            t++;
            if (pix_ready) got = 1'b1;
         end
         if (!got) begin
            chk("handshake_timeout", 0, 1);
            pix_valid = 1'b0;
            return;
         end
         if (noise && i == 5) chk("busy_in_conv", busy, 1);
         @(posedge clk); #1;
         classify = 1'b0; learn = 1'b0; load_valid = 1'b0;
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         chk("result_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
      chk("busy_after_done", busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic set_flat(input logic [31:0] v);
      for (int i = 0; i < 16; i++) cur_win[i] = v;
   endtask

   initial begin
      exp_t e;
      int unsigned s0;
      rst = 1'b1; learn = 1'b0; classify = 1'b0; load_valid = 1'b0; pix_valid = 1'b0;
      load_addr = '0; load_data = '0; pixels = '0;
      for (int k = 0; k < NK; k++) begin
         m_kern[k] = '0;
         for (int s = 0; s < NS; s++) m_w[s][k] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result", result, 0);
`ifdef CNN_SCORE_OUT_EN
      chk("rst_score", score, 0);
`endif
      @(posedge clk); #1; rst = 1'b0;

      // Kernel0 0x10 taps on 0xFF -> conv 63, shape 2 wins with 4*63.
      load_all(32'h1010_1010, 32'h0, 32'h0);
      load(6, 32'h0101_0101);
      set_flat(32'hFFFF_FFFF);
      start_class(0, 0, 0, e);
      chk("model_pin_res_a", e.res, 2);
      chk("model_pin_sc_a", e.sc, 252);
      feed(-1, 0);
      wait_idle();

      // Mixed pattern exercising non-trivial pooling and argmax.
      load_all(32'h4030_2010, 32'h08FF_0410, 32'h0);
      load(2, 32'h0102_0304); load(3, 32'h0000_0001);
      load(4, 32'h0401_0203); load(5, 32'h0202_0000);
      load(7, 32'h0003_0300); load(8, 32'h0101_0101);
      for (int i = 0; i < 16; i++)
         cur_win[i] = {8'(i * 31), 8'(255 - i * 9), 8'(i * 5 + 3), 8'(i * 17)};
      start_class(0, 0, 0, e);
      feed(-1, 0);
      wait_idle();

      // Saturation; final kernel write lands in the classify cycle.
      load_all(32'h0, 32'h0, 32'h0);
      load(4, 32'h0101_0101);
      set_flat(32'hFFFF_FFFF);
      start_class(1, 0, 32'hFFFF_FFFF, e);
      chk("model_pin_res_b", e.res, 1);
      chk("model_pin_sc_b", e.sc, 1020);
      feed(-1, 0);
      wait_idle();

      // All shapes tie -> lowest index.
      load_all(32'h1010_1010, 32'h0, 32'h0101_0101);
      start_class(0, 0, 0, e);
      chk("model_pin_res_tie", e.res, 0);
      chk("model_pin_sc_tie", e.sc, 252);
      feed(-1, 0);
      wait_idle();

      // Gap, busy-time classify/writes and an out-of-range write are all inert.
      load_all(32'h1010_1010, 32'h0, 32'h0);
      load(6, 32'h0101_0101);
      load(10, 32'hFFFF_FFFF);
      s0 = n_strobe;
      start_class(0, 0, 0, e);
      feed(8, 1);
      repeat (10) @(posedge clk);
      #1;
      classify = 1'b1; learn = 1'b1; load_valid = 1'b1; load_addr = 5'd2; load_data = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      classify = 1'b0; learn = 1'b0; load_valid = 1'b0;
      wait_idle();
      chk("single_strobe", n_strobe - s0, 1);
      start_class(0, 0, 0, e);
      chk("model_pin_res_repeat", e.res, 2);
      feed(-1, 0);
      wait_idle();

      // Reset during FC aborts and wipes stored weights.
      s0 = n_strobe;
      start_class(0, 0, 0, e);
      feed(-1, 0);
      repeat (15) @(posedge clk);
      #3;
      rst = 1'b1;
      exp_q.delete();
      for (int k = 0; k < NK; k++) begin
         m_kern[k] = '0;
         for (int s = 0; s < NS; s++) m_w[s][k] = '0;
      end
      @(negedge clk);
      chk("midrst_pix_ready", pix_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_result_valid", result_valid, 0);
      chk("midrst_result", result, 0);
      @(posedge clk); #1; rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("no_strobe_after_rst", n_strobe - s0, 0);
      @(posedge clk); #1;
      start_class(0, 0, 0, e);
      feed(-1, 0);
      wait_idle();
      load_all(32'h1010_1010, 32'h0, 32'h0);
      load(6, 32'h0101_0101);
      start_class(0, 0, 0, e);
      feed(-1, 0);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
